// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter_pkg: shared encodings for the Wishbone bus arbiters        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package wb_arbiter_pkg;

  localparam int BUS_WIDTH        = 32;
  localparam int WB_ARB_TMO_WIDTH = 8;

  localparam logic [1:0] WB_ARB_IDLE = 2'd0;
  localparam logic [1:0] WB_ARB_BUSY = 2'd1;
  localparam logic [1:0] WB_ARB_ERR  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_rr_pick: combinational round-robin picker, first requester     |
// | strictly after 'last', wrapping around.  Revision: 1.0                |
// +----------------------------------------------------------------------+
module wb_arb_rr_pick #(
  parameter int NM    = 2,
  parameter int IDX_W = $clog2(NM)
) (
  input  logic [NM-1:0]    req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NM; k >= 1; k--) begin
      if (req[IDX_W'((int'(last) + k) % NM)]) begin
        grant_idx   = IDX_W'((int'(last) + k) % NM);
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter: round-robin Wishbone classic arbiter with cycle locking   |
// | and a per-transfer watchdog.  Revision: 1.0                           |
// +----------------------------------------------------------------------+
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NM         = 2,
  parameter int addr_width = BUS_WIDTH,
  parameter int data_width = BUS_WIDTH,
  parameter int sel_width  = data_width / 8,
  parameter int timeout    = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NM-1:0]              wb_m_cyc,
  input  logic [NM-1:0]              wb_m_stb,
  input  logic [NM-1:0]              wb_m_we,
  input  logic [NM*addr_width-1:0]   wb_m_adr,
  input  logic [NM*data_width-1:0]   wb_m_datwr,
  input  logic [NM*sel_width-1:0]    wb_m_sel,
  output logic [NM-1:0]              wb_m_ack,
  output logic [NM-1:0]              wb_m_err,
  output logic [data_width-1:0]      wb_m_datrd,
  output logic                       wb_s_cyc,
  output logic                       wb_s_stb,
  output logic                       wb_s_we,
  output logic [addr_width-1:0]      wb_s_adr,
  output logic [data_width-1:0]      wb_s_datwr,
  output logic [sel_width-1:0]       wb_s_sel,
  input  logic                       wb_s_ack,
  input  logic [data_width-1:0]      wb_s_datrd
);

  localparam int IDX_W = $clog2(NM);
  localparam int TW    = WB_ARB_TMO_WIDTH;
  localparam logic [TW-1:0] TMO = TW'(timeout);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             err_first_q, err_first_d;

  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             own_cyc;
  logic             stall;
  logic [TW-1:0]    cnt_inc;

  logic [addr_width-1:0] adr_a [NM];
  logic [data_width-1:0] dat_a [NM];
  logic [sel_width-1:0]  sel_a [NM];

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign adr_a[i] = wb_m_adr[i*addr_width +: addr_width];
    assign dat_a[i] = wb_m_datwr[i*data_width +: data_width];
    assign sel_a[i] = wb_m_sel[i*sel_width +: sel_width];
  end

  wb_arb_rr_pick #(
    .NM    (NM),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (wb_m_cyc),
    .last        (last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign own_cyc = wb_m_cyc[owner_q];
  assign cnt_inc = cnt_q + TW'(1);
  assign stall   = wb_s_stb & ~wb_s_ack;

  always_comb begin
    wb_s_cyc   = 1'b0;
    wb_s_stb   = 1'b0;
    wb_s_we    = 1'b0;
    wb_s_adr   = '0;
    wb_s_datwr = '0;
    wb_s_sel   = '0;
    if (state_q == WB_ARB_BUSY) begin
      wb_s_cyc   = own_cyc;
      wb_s_stb   = wb_m_stb[owner_q];
      wb_s_we    = wb_m_we[owner_q];
      wb_s_adr   = adr_a[owner_q];
      wb_s_datwr = dat_a[owner_q];
      wb_s_sel   = sel_a[owner_q];
    end
    wb_m_datrd = reset ? wb_s_datrd : '0;
    for (int i = 0; i < NM; i++) begin
      wb_m_ack[i] = (state_q == WB_ARB_BUSY) && (owner_q == IDX_W'(i)) && wb_s_ack;
      wb_m_err[i] = (state_q == WB_ARB_ERR) && err_first_q && (owner_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    err_first_d = 1'b0;
    case (state_q)
      WB_ARB_IDLE: begin
        if (grant_valid) begin
          state_d = WB_ARB_BUSY;
          owner_d = grant_idx;
          last_d  = grant_idx;
          cnt_d   = '0;
        end
      end
      WB_ARB_BUSY: begin
        // Losing cyc wins over a watchdog expiry in the same cycle.
        if (!own_cyc) begin
          state_d = WB_ARB_IDLE;
        end else begin
          if (wb_s_ack) begin
            cnt_d = '0;
          end else if (wb_s_stb) begin
            cnt_d = cnt_inc;
          end
          if ((TMO != '0) && stall && (cnt_inc == TMO)) begin
            state_d     = WB_ARB_ERR;
            err_first_d = 1'b1;
          end
        end
      end
      WB_ARB_ERR: begin
        if (!own_cyc) begin
          state_d = WB_ARB_IDLE;
        end
      end
      default: begin
        state_d = WB_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= WB_ARB_IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NM - 1);
      cnt_q       <= '0;
      err_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_first_q <= err_first_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_arbiter: randomized self-checking bench for wb_arbiter (NM=3,   |
// | timeout=4).  Revision: 1.0                                            |
// +----------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int NM  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NM-1:0] m_cyc, m_stb, m_we;
  logic [AW-1:0] adr_v [NM];
  logic [DW-1:0] dat_v [NM];
  logic [SW-1:0] sel_v [NM];
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0] m_ack, m_err;
  logic [DW-1:0] m_datrd;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_datwr;
  logic [SW-1:0] s_sel;
  logic          s_ack;
  logic [DW-1:0] s_datrd;

  int total = 0;
  int bad   = 0;
  int exp_last;

  assign m_adr = {adr_v[2], adr_v[1], adr_v[0]};
  assign m_dat = {dat_v[2], dat_v[1], dat_v[0]};
  assign m_sel = {sel_v[2], sel_v[1], sel_v[0]};

  always #5 clock = ~clock;

  wb_arbiter #(
    .NM         (NM),
    .addr_width (AW),
    .data_width (DW),
    .sel_width  (SW),
    .timeout    (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_m_cyc   (m_cyc),
    .wb_m_stb   (m_stb),
    .wb_m_we    (m_we),
    .wb_m_adr   (m_adr),
    .wb_m_datwr (m_dat),
    .wb_m_sel   (m_sel),
    .wb_m_ack   (m_ack),
    .wb_m_err   (m_err),
    .wb_m_datrd (m_datrd),
    .wb_s_cyc   (s_cyc),
    .wb_s_stb   (s_stb),
    .wb_s_we    (s_we),
    .wb_s_adr   (s_adr),
    .wb_s_datwr (s_datwr),
    .wb_s_sel   (s_sel),
    .wb_s_ack   (s_ack),
    .wb_s_datrd (s_datrd)
  );

  // Reference rule: first requester strictly after 'last', ascending, wrapping.
  function automatic int pick(logic [NM-1:0] req, int last);
    for (int k = 1; k <= NM; k++) begin
      int idx;
      idx = (last + k) % NM;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic next_drive();
    @(posedge clock);
    #1;
  endtask

  task automatic to_check();
    @(negedge clock);
  endtask

  // Master i's address carries its index in bits [29:28].
  task automatic payload();
    for (int i = 0; i < NM; i++) begin
      adr_v[i] = {2'b00, 2'(i), 12'h000, 16'($urandom)};
      dat_v[i] = $urandom;
      sel_v[i] = 4'($urandom);
      m_we[i]  = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    reset = 1'b0; s_ack = 1'b1; s_datrd = $urandom;
    payload();
    m_cyc = 3'b011; m_stb = 3'b011;
    repeat (2) next_drive();
    to_check();
    total++;
    if ({s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel} !== '0) begin
      bad++; $display("FAIL reset_slave: got %h want 0", {s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel});
    end
    total++;
    if ({m_ack, m_err, m_datrd} !== '0) begin
      bad++; $display("FAIL reset_master: got %h want 0", {m_ack, m_err, m_datrd});
    end
    next_drive(); reset = 1'b1; s_ack = 1'b0;
    to_check();
    total++;
    if (s_cyc !== 1'b0) begin bad++; $display("FAIL reset_release_idle: s_cyc=%b want 0", s_cyc); end
    exp_last = NM - 1;
    next_drive();
    to_check();
    exp_last = pick(3'b011, exp_last);
    total++;
    if (s_cyc !== 1'b1 || int'(s_adr[29:28]) !== exp_last) begin
      bad++; $display("FAIL reset_first_grant: cyc=%b owner=%0d want 1/%0d", s_cyc, s_adr[29:28], exp_last);
    end
    total++;
    if (s_datwr !== dat_v[0] || s_sel !== sel_v[0] || s_we !== m_we[0]) begin
      bad++; $display("FAIL reset_mux: dat=%h sel=%h we=%b want %h/%h/%b", s_datwr, s_sel, s_we, dat_v[0], sel_v[0], m_we[0]);
    end
    next_drive(); s_ack = 1'b1; rd = $urandom; s_datrd = rd;
    to_check();
    total++;
    if (m_ack !== 3'b001 || m_datrd !== rd) begin
      bad++; $display("FAIL reset_ack: ack=%b rd=%h want 001/%h", m_ack, m_datrd, rd);
    end
    next_drive(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    next_drive();
    to_check();
    total++;
    if (s_cyc !== 1'b0) begin bad++; $display("FAIL handoff_idle: s_cyc=%b want 0", s_cyc); end
    next_drive();
    to_check();
    exp_last = pick(m_cyc, exp_last);
    total++;
    if (s_cyc !== 1'b1 || int'(s_adr[29:28]) !== exp_last) begin
      bad++; $display("FAIL handoff_grant: cyc=%b owner=%0d want 1/%0d", s_cyc, s_adr[29:28], exp_last);
    end
    next_drive(); m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_lock();
    int d;
    logic [AW-1:0] a;
    payload();
    adr_v[0] = 32'h0000_0F00;
    adr_v[1] = 32'h0000_0100;
    m_cyc = 3'b010; m_stb = 3'b010;
    next_drive();
    exp_last = pick(3'b010, exp_last);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      a = 32'h100 + 32'(4 * t);
      adr_v[1] = a;
      d = $urandom_range(0, 2);
      repeat (d) begin
        to_check();
        total++;
        if (s_cyc !== 1'b1 || s_adr !== a || m_ack !== 3'b000 || m_err !== 3'b000) begin
          bad++; $display("FAIL lock_wait: cyc=%b adr=%h ack=%b err=%b want 1/%h/000/000", s_cyc, s_adr, m_ack, m_err, a);
        end
        next_drive();
      end
      s_ack = 1'b1;
      to_check();
      total++;
      if (m_ack !== 3'b010 || s_adr !== a) begin
        bad++; $display("FAIL lock_ack%0d: ack=%b adr=%h want 010/%h", t, m_ack, s_adr, a);
      end
      next_drive(); s_ack = 1'b0;
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    next_drive();
    to_check();
    total++;
    if (s_cyc !== 1'b0) begin bad++; $display("FAIL lock_release_idle: s_cyc=%b want 0", s_cyc); end
    next_drive();
    to_check();
    exp_last = pick(m_cyc, exp_last);
    total++;
    if (s_cyc !== 1'b1 || s_adr !== adr_v[exp_last]) begin
      bad++; $display("FAIL lock_next_grant: cyc=%b adr=%h want 1/%h", s_cyc, s_adr, adr_v[exp_last]);
    end
    next_drive(); m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_round_robin();
    int exp, d;
    logic [DW-1:0] rd;
    payload();
    reset = 1'b0; m_cyc = 3'b111; m_stb = 3'b111;
    #2 reset = 1'b1;
    exp_last = NM - 1;
    next_drive();
    for (int n = 0; n < 6; n++) begin
      exp = pick(3'b111, exp_last);
      to_check();
      total++;
      if (s_cyc !== 1'b1 || int'(s_adr[29:28]) !== exp || int'(s_adr[29:28]) !== n % NM) begin
        bad++; $display("FAIL rr_order%0d: cyc=%b owner=%0d want 1/%0d", n, s_cyc, s_adr[29:28], exp);
      end
      total++;
      if (s_datwr !== dat_v[exp] || s_sel !== sel_v[exp] || s_we !== m_we[exp] || s_stb !== 1'b1) begin
        bad++; $display("FAIL rr_mux%0d: dat=%h sel=%h we=%b want %h/%h/%b", n, s_datwr, s_sel, s_we, dat_v[exp], sel_v[exp], m_we[exp]);
      end
      d = $urandom_range(0, 2);
      repeat (d) begin
        next_drive();
        to_check();
        total++;
        if (m_err !== 3'b000 || s_cyc !== 1'b1) begin
          bad++; $display("FAIL rr_stall%0d: err=%b cyc=%b want 000/1", n, m_err, s_cyc);
        end
      end
      next_drive(); s_ack = 1'b1; rd = $urandom; s_datrd = rd;
      to_check();
      total++;
      if (m_ack !== (3'b001 << exp) || m_datrd !== rd || m_err !== 3'b000) begin
        bad++; $display("FAIL rr_ack%0d: ack=%b rd=%h err=%b want %b/%h/000", n, m_ack, m_datrd, m_err, 3'b001 << exp, rd);
      end
      next_drive(); s_ack = 1'b0; m_cyc[exp] = 1'b0;
      next_drive(); m_cyc[exp] = 1'b1;
      to_check();
      total++;
      if (s_cyc !== 1'b0) begin bad++; $display("FAIL rr_idle%0d: s_cyc=%b want 0", n, s_cyc); end
      next_drive();
      exp_last = exp;
      payload();
    end
    exp_last = pick(3'b111, exp_last);
    m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_timeout();
    int r, q;
    payload();
    r = $urandom_range(0, NM - 1);
    m_cyc = 3'b001 << r; m_stb = 3'b001 << r; s_ack = 1'b0;
    next_drive();
    exp_last = r;
    for (int c = 1; c <= 6; c++) begin
      to_check();
      total++;
      if (c <= TMO) begin
        if (m_err !== 3'b000 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin
          bad++; $display("FAIL tmo_stall%0d: err=%b cyc=%b stb=%b want 000/1/1", c, m_err, s_cyc, s_stb);
        end
      end else if (c == TMO + 1) begin
        if (m_err !== (3'b001 << r) || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
          bad++; $display("FAIL tmo_err_pulse: err=%b cyc=%b stb=%b want %b/0/0", m_err, s_cyc, s_stb, 3'b001 << r);
        end
      end else begin
        if (m_err !== 3'b000 || s_cyc !== 1'b0 || m_ack !== 3'b000) begin
          bad++; $display("FAIL tmo_err_hold: err=%b cyc=%b ack=%b want 000/0/000", m_err, s_cyc, m_ack);
        end
      end
      next_drive();
      if (c == TMO + 1) s_ack = 1'b1;
    end
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    next_drive();
    q = (r + 1) % NM;
    m_cyc = 3'b001 << q; m_stb = 3'b001 << q;
    to_check();
    total++;
    if (s_cyc !== 1'b0 || m_err !== 3'b000) begin
      bad++; $display("FAIL tmo_idle: cyc=%b err=%b want 0/000", s_cyc, m_err);
    end
    next_drive();
    to_check();
    exp_last = pick(m_cyc, exp_last);
    total++;
    if (s_cyc !== 1'b1 || int'(s_adr[29:28]) !== exp_last) begin
      bad++; $display("FAIL tmo_regrant: cyc=%b owner=%0d want 1/%0d", s_cyc, s_adr[29:28], exp_last);
    end
    next_drive(); m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_ack_at_limit();
    int r;
    payload();
    r = $urandom_range(0, NM - 1);
    m_cyc = 3'b001 << r; m_stb = 3'b001 << r;
    next_drive();
    exp_last = r;
    for (int c = 1; c <= TMO + 1; c++) begin
      to_check();
      total++;
      if (c == TMO) begin
        if (m_ack !== (3'b001 << r) || m_datrd !== 32'hDEADBEEF || m_err !== 3'b000) begin
          bad++; $display("FAIL limit_ack: ack=%b rd=%h err=%b want %b/deadbeef/000", m_ack, m_datrd, m_err, 3'b001 << r);
        end
      end else begin
        if (m_err !== 3'b000 || s_cyc !== 1'b1) begin
          bad++; $display("FAIL limit_cycle%0d: err=%b cyc=%b want 000/1", c, m_err, s_cyc);
        end
      end
      next_drive();
      if (c == TMO - 1) begin s_ack = 1'b1; s_datrd = 32'hDEADBEEF; end
      if (c == TMO) s_ack = 1'b0;
    end
    m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_drop_at_limit();
    int r;
    payload();
    r = $urandom_range(0, NM - 1);
    m_cyc = 3'b001 << r; m_stb = 3'b001 << r;
    next_drive();
    exp_last = r;
    repeat (TMO - 1) next_drive();
    m_cyc = '0;
    for (int c = TMO; c <= TMO + 2; c++) begin
      to_check();
      total++;
      if (m_err !== 3'b000 || s_cyc !== 1'b0) begin
        bad++; $display("FAIL drop_limit%0d: err=%b cyc=%b want 000/0", c, m_err, s_cyc);
      end
      next_drive();
    end
    m_stb = '0;
    next_drive();
  endtask

  task automatic test_async_reset();
    int r;
    payload();
    r = $urandom_range(0, NM - 1);
    m_cyc = 3'b001 << r; m_stb = 3'b001 << r;
    next_drive();
    exp_last = r;
    to_check();
    total++;
    if (s_cyc !== 1'b1) begin bad++; $display("FAIL areset_pre: s_cyc=%b want 1", s_cyc); end
    #2;
    s_ack = 1'b1; s_datrd = $urandom;
    reset = 1'b0;
    #1;
    total++;
    if ({s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel} !== '0) begin
      bad++; $display("FAIL areset_slave: got %h want 0", {s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel});
    end
    total++;
    if ({m_ack, m_err, m_datrd} !== '0) begin
      bad++; $display("FAIL areset_master: got %h want 0", {m_ack, m_err, m_datrd});
    end
    m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b0;
    next_drive(); reset = 1'b1;
    exp_last = NM - 1;
    next_drive();
    to_check();
    exp_last = pick(3'b111, exp_last);
    total++;
    if (s_cyc !== 1'b1 || int'(s_adr[29:28]) !== exp_last) begin
      bad++; $display("FAIL areset_regrant: cyc=%b owner=%0d want 1/%0d", s_cyc, s_adr[29:28], exp_last);
    end
    next_drive(); m_cyc = '0; m_stb = '0;
    next_drive();
  endtask

  task automatic test_random();
    int exp;
    logic [NM-1:0] mask;
    logic [DW-1:0] rd;
    for (int n = 0; n < 40; n++) begin
      payload();
      mask = NM'($urandom_range(1, 7));
      m_cyc = mask; m_stb = mask;
      exp = pick(mask, exp_last);
      next_drive();
      // Non-owners come and go while the owner holds the bus.
      m_cyc = NM'($urandom) | (3'b001 << exp);
      to_check();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== adr_v[exp] || s_datwr !== dat_v[exp] || s_sel !== sel_v[exp] || s_we !== m_we[exp]) begin
        bad++; $display("FAIL rand_grant%0d: cyc=%b adr=%h want 1/%h (mask=%b)", n, s_cyc, s_adr, adr_v[exp], mask);
      end
      next_drive(); s_ack = 1'b1; rd = $urandom; s_datrd = rd;
      m_cyc = NM'($urandom) | (3'b001 << exp);
      to_check();
      total++;
      if (m_ack !== (3'b001 << exp) || m_datrd !== rd || m_err !== 3'b000) begin
        bad++; $display("FAIL rand_ack%0d: ack=%b rd=%h want %b/%h", n, m_ack, m_datrd, 3'b001 << exp, rd);
      end
      next_drive(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      next_drive();
      exp_last = exp;
    end
  endtask

  initial begin
    reset = 1'b0; s_ack = 1'b0; s_datrd = '0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < NM; i++) begin
      adr_v[i] = '0; dat_v[i] = '0; sel_v[i] = '0;
    end
    exp_last = NM - 1;
    test_reset();
    test_lock();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_drop_at_limit();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
